// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op codes, FSM states and status bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_OR  = 3'b001,
    OP_SLL = 3'b010,
    OP_EQ  = 3'b011,
    OP_SUB = 3'b100,
    OP_AND = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int ST_V = 3;
  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_C = 0;

  function automatic logic [3:0] mk_status(input logic v, input logic z,
                                           input logic n, input logic c);
    logic [3:0] s;
    s       = '0;
    s[ST_V] = v;
    s[ST_Z] = z;
    s[ST_N] = n;
    s[ST_C] = c;
    return s;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;
  logic             run;

  // Final partial product folds in combinationally so done and prod line up.
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH - 1);
      run    <= 1'b1;
    end else if (run) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops complete in one cycle, MUL runs on the iterative multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       status,
  output logic             busy
);

  localparam int M = WIDTH - 1;

  state_e           state, state_nxt;
  op_e              op_i;
  logic             accept, mul_start, mul_done;
  logic [WIDTH-1:0] mul_prod, res;
  logic [WIDTH:0]   sum, dif;
  logic             cy, ov;

  assign op_i      = op_e'(op);
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_i == OP_MUL);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (din1),
    .b     (din2),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Subtract as din1 + ~din2 + 1 so the carry-out is directly NOT borrow.
  always_comb begin
    sum = {1'b0, din1} + {1'b0, din2};
    dif = {1'b0, din1} + {1'b0, ~din2} + {{WIDTH{1'b0}}, 1'b1};
    res = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    case (op_i)
      OP_ADD: begin
        res = sum[M:0];
        cy  = sum[WIDTH];
        ov  = (din1[M] == din2[M]) && (res[M] != din1[M]);
      end
      OP_OR:  res = din1 | din2;
      OP_SLL: res = din1 << din2[SHW-1:0];
      OP_EQ:  res = {{(WIDTH-1){1'b0}}, (din1 == din2)};
      OP_SUB: begin
        res = dif[M:0];
        cy  = dif[WIDTH];
        ov  = (din1[M] != din2[M]) && (res[M] != din1[M]);
      end
      OP_AND: res = din1 & din2;
      OP_SRA: res = WIDTH'($signed(din1) >>> din2[SHW-1:0]);
      default: res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (op_i == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (mul_done) state_nxt = S_DONE;
      S_DONE: begin
        if (accept)         state_nxt = (op_i == OP_MUL) ? S_MUL : S_DONE;
        else if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Output registers only move on a new result, which keeps them stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      status <= '0;
    end else if (accept && (op_i != OP_MUL)) begin
      dout   <= res;
      status <= mk_status(ov, (res == '0), res[M], cy);
    end else if ((state == S_MUL) && mul_done) begin
      dout   <= mul_prod;
      status <= mk_status(1'b0, (mul_prod == '0), mul_prod[M], 1'b0);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq with directed corner cases and reset mid-multiply.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] din1 = '0, din2 = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] dout;
  logic [3:0]   status;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .din1(din1), .din2(din2), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; logic [3:0] s; } exp_t;

  exp_t sbq[$];
  int   pop_cyc[$];
  int   checks = 0, failures = 0, cyc = 0, bp_mode = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, sr;
    longint unsigned ua, ub, ur;
    logic [W-1:0] r;
    bit v, c;
    int sh;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a); ub = longint'(b);
    sh = int'(b % W);
    v = 0; c = 0; r = '0;
    case (o)
      3'd0: begin
        ur = ua + ub; r = ur[W-1:0]; c = (ur >> W) != 0;
        sr = sa + sb; v = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
      end
      3'd1: r = a | b;
      3'd2: r = a << sh;
      3'd3: r = (a == b) ? 1 : 0;
      3'd4: begin
        r = a - b; c = (ua >= ub);
        sr = sa - sb; v = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
      end
      3'd5: r = a & b;
      3'd6: begin
        r = a >> sh;
        if (a[W-1]) r = r | ~({W{1'b1}} >> sh);
      end
      default: begin ur = ua * ub; r = ur[W-1:0]; end
    endcase
    e.d = r;
    e.s = {v, (r == 0), r[W-1], c};
    return e;
  endfunction

  // Back-pressure generator runs after the driver's updates in each cycle.
  initial forever begin
    @(posedge clk); #2;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on each output handshake and checks hold stability.
  initial begin
    bit hold = 0;
    logic [W-1:0] hd;
    logic [3:0] hs;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 0;
      else begin
        if (hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_dout", dout, hd);
          chk("hold_status", status, hs);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) chk("unexpected_out", out_valid, 0);
          else begin
            e = sbq.pop_front();
            chk("dout", dout, e.d);
            chk("status", status, e.s);
            pop_cyc.push_back(cyc);
          end
        end
        hold = out_valid && !out_ready;
        hd = dout; hs = status;
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    op = o; din1 = a; din2 = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin sbq.push_back(model(o, a, b)); break; end
      n++;
      if (n > 200) begin chk("accept_timeout", in_ready, 1); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); din1 = $urandom; din2 = $urandom;
  endtask

  task automatic set_bp(input int m);
    bp_mode = m;
    if (m == 0) out_ready = 1'b1;
    if (m == 2) out_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    set_bp(0);
    while ((sbq.size() != 0 || out_valid) && n < 500) begin @(posedge clk); n++; end
    if (n >= 500) chk("drain_timeout", 64'(sbq.size()), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, busy_cnt, bad_rdy, k;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_status", status, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    set_bp(0);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // ADD overflow into sign bit, one-cycle latency
    send(3'd0, 32'h7FFFFFFF, 32'h1);
    @(negedge clk);
    chk("add_latency", out_valid, 1);
    chk("add_dout", dout, 32'h80000000);
    chk("add_status", status, 4'b1010);
    @(posedge clk); #1;
    send(3'd4, 32'd5, 32'd5);
    send(3'd4, 32'd0, 32'd1);
    send(3'd2, 32'd1, 32'h21);
    send(3'd6, 32'h80000000, 32'd4);
    drain();

    // MUL: busy for W cycles, result on cycle W+1
    send(3'd7, 32'h10000, 32'h10003);
    n = 0; busy_cnt = 0; bad_rdy = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (out_valid) break;
      if (busy) busy_cnt++;
      if (in_ready) bad_rdy++;
    end
    chk("mul_busy_cycles", busy_cnt, 32);
    chk("mul_latency", n, 33);
    chk("mul_in_ready_low", bad_rdy, 0);
    chk("mul_dout", dout, 32'h00030000);
    @(posedge clk); #1;
    drain();

    // Back-pressure on EQ, then back-to-back ADDs
    set_bp(2);
    @(posedge clk); #1;
    send(3'd3, 32'd7, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_dout", dout, 1);
    end
    @(posedge clk); #1;
    set_bp(0);
    pop_cyc.delete();
    send(3'd0, 32'd10, 32'd20);
    send(3'd0, 32'hFFFFFFFF, 32'd1);
    send(3'd0, 32'h80000000, 32'h80000000);
    drain();
    k = pop_cyc.size();
    chk("b2b_count", k, 4);
    if (k == 4) begin
      chk("b2b_gap1", pop_cyc[1] - pop_cyc[0], 1);
      chk("b2b_gap2", pop_cyc[2] - pop_cyc[1], 1);
      chk("b2b_gap3", pop_cyc[3] - pop_cyc[2], 1);
    end

    // Reset in the middle of a multiply
    send(3'd7, $urandom, $urandom);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_status", status, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_no_valid", out_valid, 0);
    @(posedge clk); #1;
    send(3'd7, 32'd12345, 32'd678);
    send(3'd5, 32'hF0F0F0F0, 32'h0FF00FF0);
    drain();

    // Randomized traffic under random back-pressure
    set_bp(1);
    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();
    chk("final_queue_empty", 64'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=%0t expected=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
